// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes
// and for sign correction of results.
module mul_div_unit_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on unsigned magnitudes; signs are applied on the final step.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | accepts START (wins over MTHI/MTLO) or MTHI/MTLO writes
//   ST_RUN  | one iteration per cycle; HI/LO written on the last one
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    input  logic             MTHI,
    input  logic             MTLO,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opd;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_done;

    logic                 w_launch;
    logic                 w_last;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_nxt;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_launch    = (r_state == ST_IDLE) && START;
    assign w_last      = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
    assign w_is_div    = (OP == OP_DIV) || (OP == OP_DIVU);
    assign w_is_signed = (OP == OP_MULT) || (OP == OP_DIV);
    assign w_neg_a     = w_is_signed && SRC_A[WIDTH-1];
    assign w_neg_b     = w_is_signed && SRC_B[WIDTH-1];

    // Magnitudes are unsigned WIDTH-bit values, so the most-negative input
    // maps to 2^(WIDTH-1) without overflow.
    mul_div_unit_sign_fix #(.W(WIDTH)) u_abs_a (
        .i_val (SRC_A),
        .i_neg (w_neg_a),
        .o_val (w_mag_a)
    );

    mul_div_unit_sign_fix #(.W(WIDTH)) u_abs_b (
        .i_val (SRC_B),
        .i_neg (w_neg_b),
        .o_val (w_mag_b)
    );

    // Multiply: add multiplicand into the upper half when the LSB is set,
    // then shift the whole accumulator right with the carry.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
    assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient bits in. A zero divisor never restores,
    // giving an all-ones quotient and the dividend as remainder.
    assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = w_shift >= {1'b0, r_opd};
    assign w_diff    = w_shift[WIDTH-1:0] - r_opd;
    assign w_div_nxt = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                            : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;

    mul_div_unit_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .i_val (w_acc_nxt),
        .i_neg (r_neg_q),
        .o_val (w_prod)
    );

    mul_div_unit_sign_fix #(.W(WIDTH)) u_fix_quo (
        .i_val (w_acc_nxt[WIDTH-1:0]),
        .i_neg (r_neg_q),
        .o_val (w_quo)
    );

    mul_div_unit_sign_fix #(.W(WIDTH)) u_fix_rem (
        .i_val (w_acc_nxt[2*WIDTH-1:WIDTH]),
        .i_neg (r_neg_r),
        .o_val (w_rem)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (START) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO writes and DONE pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_launch) begin
                r_div   <= w_is_div;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_is_div && w_neg_a;
                r_opd   <= w_is_div ? w_mag_b : w_mag_a;
                r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                r_cnt   <= CNT_W'(WIDTH);
            end else if (r_state == ST_RUN) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
                end
            end else begin
                if (MTHI) r_hi <= SRC_A;
                if (MTLO) r_lo <= SRC_A;
            end
        end
    end

    assign BUSY = (r_state == ST_RUN);
    assign DONE = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam vec_t MUL_VEC [6] = '{
        '{2'b01, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A},
        '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
        '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000},
        '{2'b00, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'h00000000, 32'h00000018}
    };

    localparam vec_t DIV_VEC [7] = '{
        '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
        '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
        '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{2'b11, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999},
        '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001}
    };

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] SRC_A;
    logic [31:0] SRC_B;
    logic        MTHI;
    logic        MTLO;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .SRC_A (SRC_A),
        .SRC_B (SRC_B),
        .MTHI  (MTHI),
        .MTLO  (MTLO),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
        .LO    (LO)
    );

    // Called at a falling edge; holds the request for one rising edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic mthi,
                            input logic mtlo);
        START = 1'b1; OP = op; SRC_A = a; SRC_B = b; MTHI = mthi; MTLO = mtlo;
        @(negedge CLK);
        START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
    endtask

    // Advances falling edges until DONE is seen or the budget expires.
    task automatic wait_done(output int busy_n, output int cyc, output bit seen);
        busy_n = 0; cyc = 0; seen = 1'b0;
        while (cyc < 100 && !seen) begin
            if (DONE) begin
                seen = 1'b1;
            end else begin
                if (BUSY) busy_n++;
                @(negedge CLK);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; START = 1'b0; OP = 2'b00; SRC_A = '0; SRC_B = '0;
        MTHI = 1'b0; MTLO = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", DONE); end
        n_vec++; if (HI !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h exp 00000000", HI); end
        n_vec++; if (LO !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h exp 00000000", LO); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_multiply();
        int  busy_n, cyc;
        bit  seen;
        for (int i = 0; i < 6; i++) begin
            start_op(MUL_VEC[i].op, MUL_VEC[i].a, MUL_VEC[i].b, 1'b0, 1'b0);
            n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL mul%0d_done_pulse got %b exp 0", i, DONE); end
            wait_done(busy_n, cyc, seen);
            n_vec++; if (!seen) begin n_err++; $display("FAIL mul%0d_timeout got no DONE exp DONE", i); end
            n_vec++; if (busy_n != 32) begin n_err++; $display("FAIL mul%0d_busy got %0d exp 32", i, busy_n); end
            n_vec++; if (HI !== MUL_VEC[i].hi) begin n_err++; $display("FAIL mul%0d_hi got %h exp %h", i, HI, MUL_VEC[i].hi); end
            n_vec++; if (LO !== MUL_VEC[i].lo) begin n_err++; $display("FAIL mul%0d_lo got %h exp %h", i, LO, MUL_VEC[i].lo); end
        end
    endtask

    task automatic test_divide();
        int  busy_n, cyc;
        bit  seen;
        for (int i = 0; i < 7; i++) begin
            start_op(DIV_VEC[i].op, DIV_VEC[i].a, DIV_VEC[i].b, 1'b0, 1'b0);
            wait_done(busy_n, cyc, seen);
            n_vec++; if (!seen) begin n_err++; $display("FAIL div%0d_timeout got no DONE exp DONE", i); end
            n_vec++; if (busy_n != 32) begin n_err++; $display("FAIL div%0d_busy got %0d exp 32", i, busy_n); end
            n_vec++; if (HI !== DIV_VEC[i].hi) begin n_err++; $display("FAIL div%0d_hi got %h exp %h", i, HI, DIV_VEC[i].hi); end
            n_vec++; if (LO !== DIV_VEC[i].lo) begin n_err++; $display("FAIL div%0d_lo got %h exp %h", i, LO, DIV_VEC[i].lo); end
        end
        @(negedge CLK);
        n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL div_done_pulse got %b exp 0", DONE); end
    endtask

    task automatic test_move();
        int  busy_n, cyc;
        bit  seen;
        MTHI = 1'b1; SRC_A = 32'h12345678;
        @(negedge CLK);
        MTHI = 1'b0;
        n_vec++; if (HI !== 32'h12345678) begin n_err++; $display("FAIL mthi got %h exp 12345678", HI); end
        n_vec++; if (LO !== 32'h00000001) begin n_err++; $display("FAIL mthi_lo_kept got %h exp 00000001", LO); end
        MTLO = 1'b1; SRC_A = 32'h0BADBEEF;
        @(negedge CLK);
        MTLO = 1'b0;
        n_vec++; if (LO !== 32'h0BADBEEF) begin n_err++; $display("FAIL mtlo got %h exp 0badbeef", LO); end
        n_vec++; if (HI !== 32'h12345678) begin n_err++; $display("FAIL mtlo_hi_kept got %h exp 12345678", HI); end
        MTHI = 1'b1; MTLO = 1'b1; SRC_A = 32'hCAFEF00D;
        @(negedge CLK);
        MTHI = 1'b0; MTLO = 1'b0;
        n_vec++; if (HI !== 32'hCAFEF00D) begin n_err++; $display("FAIL mt_both_hi got %h exp cafef00d", HI); end
        n_vec++; if (LO !== 32'hCAFEF00D) begin n_err++; $display("FAIL mt_both_lo got %h exp cafef00d", LO); end
        // START/MTHI/MTLO while running must all be ignored.
        start_op(2'b01, 32'd5, 32'd5, 1'b0, 1'b0);
        START = 1'b1; OP = 2'b11; MTHI = 1'b1; MTLO = 1'b1;
        SRC_A = 32'hDEADBEEF; SRC_B = 32'd1;
        @(negedge CLK);
        START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        n_vec++; if (HI !== 32'hCAFEF00D) begin n_err++; $display("FAIL run_mthi got %h exp cafef00d", HI); end
        n_vec++; if (LO !== 32'hCAFEF00D) begin n_err++; $display("FAIL run_mtlo got %h exp cafef00d", LO); end
        wait_done(busy_n, cyc, seen);
        n_vec++; if (!seen || busy_n != 31) begin n_err++; $display("FAIL run_ignore_start got busy %0d seen %0d exp busy 31 seen 1", busy_n, seen); end
        n_vec++; if (HI !== 32'h0) begin n_err++; $display("FAIL run_result_hi got %h exp 00000000", HI); end
        n_vec++; if (LO !== 32'h19) begin n_err++; $display("FAIL run_result_lo got %h exp 00000019", LO); end
        // START wins over a simultaneous MTLO.
        start_op(2'b01, 32'd2, 32'd2, 1'b0, 1'b1);
        n_vec++; if (LO !== 32'h19) begin n_err++; $display("FAIL start_mtlo_drop got %h exp 00000019", LO); end
        wait_done(busy_n, cyc, seen);
        n_vec++; if (!seen || LO !== 32'h4) begin n_err++; $display("FAIL start_mtlo_result got %h seen %0d exp 00000004", LO, seen); end
    endtask

    task automatic test_back_to_back();
        int  busy_n, cyc;
        bit  seen;
        start_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
        wait_done(busy_n, cyc, seen);
        n_vec++; if (!seen || LO !== 32'd6) begin n_err++; $display("FAIL b2b_first got %h seen %0d exp 00000006", LO, seen); end
        start_op(2'b01, 32'd4, 32'd5, 1'b0, 1'b0);
        n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy %b exp 1", BUSY); end
        wait_done(busy_n, cyc, seen);
        n_vec++; if (!seen || cyc + 1 != 33) begin n_err++; $display("FAIL b2b_latency got %0d exp 33", cyc + 1); end
        n_vec++; if (LO !== 32'd20 || HI !== 32'd0) begin n_err++; $display("FAIL b2b_second got %h_%h exp 00000000_00000014", HI, LO); end
    endtask

    task automatic test_reset_mid();
        int  busy_n, cyc;
        bit  seen;
        int  stray;
        start_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (9) @(negedge CLK);
        RST = 1'b0;
        #1;
        n_vec++; if (HI !== 32'h0 || LO !== 32'h0) begin n_err++; $display("FAIL rstmid_hilo got %h_%h exp 00000000_00000000", HI, LO); end
        n_vec++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got busy %b done %b exp 0 0", BUSY, DONE); end
        @(negedge CLK);
        RST = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) stray++;
        end
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL rstmid_no_done got %0d active cycles exp 0", stray); end
        start_op(2'b01, 32'd3, 32'd3, 1'b0, 1'b0);
        wait_done(busy_n, cyc, seen);
        n_vec++; if (!seen || LO !== 32'd9 || HI !== 32'd0) begin n_err++; $display("FAIL rstmid_restart got %h_%h seen %0d exp 00000000_00000009", HI, LO, seen); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_move();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: Mul_Div_Unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 Parameter CNT_W, default 6: iteration counter width; SHALL hold the value WIDTH.
REQ-003 Reset RST SHALL be asynchronous and active-low; clock CLK.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 START  input  1  launch operation; sampled only in IDLE.
REQ-007 OP  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 SRC_A  input  WIDTH  multiplicand or dividend (register-file RD1 via ID/EX).
REQ-009 SRC_B  input  WIDTH  multiplier or divisor (register-file RD2 via ID/EX).
REQ-010 MTHI  input  1  write SRC_A to HI.
REQ-011 MTLO  input  1  write SRC_A to LO.
REQ-012 BUSY  output  1  operation in progress; the pipeline stalls MFHI/MFLO/MULT/DIV while it is high.
REQ-013 DONE  output  1  one-cycle pulse when HI/LO have been updated.
REQ-014 HI  output  WIDTH  HI register (product upper half or remainder).
REQ-015 LO  output  WIDTH  LO register (product lower half or quotient).

Function
REQ-016 The FSM SHALL have states IDLE and RUN, plus a registered DONE flag.
REQ-017 IDLE with START=1: SHALL latch operand magnitudes, OP, and result sign flags; load counter with WIDTH; enter RUN on the next edge.
REQ-018 RUN SHALL perform one iteration per cycle and decrement the counter.
REQ-019 Multiply iteration: shift-add on a 2*WIDTH accumulator.
REQ-020 Divide iteration: restoring shift-subtract.
REQ-021 On the cycle the counter reaches 0, the FSM SHALL write sign-corrected HI/LO, pulse DONE for one cycle, and return to IDLE.
REQ-022 Latency SHALL be: START edge, then exactly WIDTH cycles with BUSY=1, with HI/LO valid and DONE=1 in the following cycle.
REQ-023 BUSY SHALL be high exactly while in RUN.
REQ-024 START, MTHI, and MTLO SHALL be ignored while in RUN.
REQ-025 HI/LO SHALL hold their previous values throughout RUN.
REQ-026 Signed operations SHALL use absolute values internally.
REQ-027 Signed product SHALL be negated when the operand signs differ.
REQ-028 Signed quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-029 The most-negative value (0x80000000) SHALL be handled via WIDTH+1-bit magnitude arithmetic with no overflow trap.
REQ-030 Divide by zero SHALL raise no exception; the result SHALL be unsigned LO=all ones, HI=dividend magnitude, with signed correction applied per REQ-028.
REQ-031 MTHI/MTLO in IDLE SHALL update the target register on the next edge; both asserted together SHALL write both registers.
REQ-032 START together with MTHI/MTLO in IDLE: START SHALL win and the MT write SHALL be dropped.
REQ-033 Back-to-back operation: START is accepted in the same cycle that DONE=1.

Reset
REQ-034 RST low SHALL, at any time including mid-RUN, force IDLE, BUSY=0, DONE=0, HI=0, LO=0, counter=0, and clear internal operand/accumulator registers.
REQ-035 An operation aborted by reset SHALL produce no DONE after reset release.

Structure
REQ-036 A shared package SHALL hold the OP encodings (MULT/MULTU/DIV/DIVU), the FSM state encoding, and the WIDTH default.
REQ-037 One sub-module, Sign_Fix, SHALL provide combinational conditional two's-complement negation, instantiated for operand absolute value and for result correction.
REQ-038 Everything else SHALL stay in Mul_Div_Unit; target size is 150-300 lines.

Verification
REQ-039 MULTU 7 x 6 -> BUSY high 32 cycles, then DONE with HI=0x00000000, LO=0x0000002A.
REQ-040 MULT 0xFFFFFFFD(-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-041 DIV 0xFFFFFFF9(-7) / 2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-042 MTHI with SRC_A=0x12345678 in IDLE -> HI=0x12345678 next cycle; the same during RUN -> HI unchanged; START+MTLO together -> LO receives only the operation result.
REQ-043 START DIVU 100/7, RST low at RUN cycle 10 -> HI=LO=0, BUSY=0 immediately, no DONE after release; a new MULTU 3x3 -> LO=9.
REQ-044 Back-to-back: second START in the DONE cycle -> second result DONE exactly WIDTH+1 cycles later.
